prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader that fills the core's instruction memory and then releases the core from reset.
- This is the write/load side of core bring-up; the register-dump testbench covers the read side.
- Sits between a byte source (bench or UART receiver) and the instruction-memory write port.
- Holds core_rstb low while loading, then drives it high so the core starts fetching at word 0.

Parameters:
- ADDR_WIDTH, 8, width of the word address into instruction memory; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 0, word address of the first word written.

Ports:
- clk  in  1  system clock, rising-edge.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; in DONE, begins a new load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word write address.
- mem_wdata  out  32  word write data.
- core_rstb  out  1  active-low reset to mips_core.
- busy  out  1  load in progress (any state except DONE).
- err  out  1  sticky; header count exceeded memory depth.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rstb).
- Reset values:
  - state = HDR_HI, in_ready = 1, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0.
  - core_rstb = 0, busy = 1, err = 0.
  - Internal byte counter = 0, word count = 0, words-left = 0.
- A byte is accepted on a rising edge with in_valid && in_ready. No other byte is consumed.
- in_ready is 1 in HDR_HI, HDR_LO and DATA, and 0 in DONE.
- Stream format: 16-bit word count N (big-endian, 2 bytes), then N words of 4 bytes each, big-endian (first byte = bits 31:24).
- States:
  - HDR_HI: accept byte to N[15:8] -> HDR_LO.
  - HDR_LO: accept byte to N[7:0].
    - If N == 0 -> DONE.
    - Else words-left = N, byte counter = 0, mem_addr = BASE_ADDR -> DATA.
    - If N > 2^ADDR_WIDTH - BASE_ADDR, set err = 1 (sticky until rstb or start).
  - DATA: each accepted byte shifts into the word assembly register.
    - On the 4th byte of a word, the same edge sets mem_we = 1 and loads mem_wdata with the full word. mem_addr holds the word's address during the strobe cycle.
    - On the edge after the strobe, mem_we drops to 0 and mem_addr increments by 1, wrapping modulo 2^ADDR_WIDTH.
    - Words at or beyond depth are consumed but not written: mem_we stays 0 for them.
    - When words-left reaches 0 on the 4th byte's edge -> DONE.
  - DONE: busy = 0.
    - core_rstb goes 1 on the first edge in DONE, i.e. one cycle after the last strobe, or one cycle after HDR_LO when N == 0.
    - It stays 1 until start or rstb.
- start:
  - In DONE: on the next edge, core_rstb = 0, err = 0, busy = 1, state = HDR_HI.
  - In any other state: ignored.
- Back-to-back bytes at full rate are supported: in_valid held high gives one word per 4 cycles with no bubbles. Gaps in in_valid stall the assembly with no timeout.
- A partial word is never written.
- rstb asserted mid-load: immediate return to reset values. The partially loaded memory contents are left as-is and the core stays held in reset.
- mem_we is never asserted while core_rstb = 1.

Test Plan:
- Load N=2 with words 0x20010010, 0x8C0F0100, base 0 → mem_we pulses twice:
  - (addr 0, 0x20010010), then (addr 1, 0x8C0F0100).
  - core_rstb rises exactly 1 cycle after the second strobe; busy = 0; in_ready = 0.
- Same stream with in_valid toggled 1/0 every cycle → identical writes. Each strobe follows its 4th accepted byte by one edge.
- Header N=0 → no mem_we; core_rstb = 1 one cycle after the 2nd header byte; err = 0.
- ADDR_WIDTH=2, N=5, words 1..5 → writes at addr 0..3 with data 1..4; 5th word consumed with no write; err = 1; core_rstb = 1.
- Assert rstb low after 6 data bytes of an N=3 load → all outputs return to reset values immediately. A new full N=1 stream then writes at addr 0 correctly.
- After DONE, pulse start and send N=1 word 0x0000000A → core_rstb = 0 within 1 cycle, err cleared, addr 0 written with 0x0000000A, core_rstb = 1 again.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a big-endian word count plus data words,
// writes them into instruction memory, then releases the core from reset.
module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rstb,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    DONE
  } state_t;

  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam int unsigned DEPTH    = 32'd1 << ADDR_WIDTH;
  localparam int unsigned CAPACITY = DEPTH - 32'(BASE_ADDR);

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic [7:0]    n_hi;
  logic [15:0]   hdr_n;
  logic [15:0]   words_left;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_q;
  logic [16:0]   word_idx;
  logic          last_byte;

  assign in_ready  = (state != DONE);
  assign busy      = (state != DONE);
  assign accept    = in_valid && in_ready;
  assign hdr_n     = {n_hi, in_data};
  assign last_byte = (byte_cnt == 2'd3);

  // NOTE: state register uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= HDR_HI;
    else       state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state before the case, so no
  // path through this block leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      HDR_HI: if (accept) state_nxt = HDR_LO;
      HDR_LO: if (accept) state_nxt = (hdr_n == 16'd0) ? DONE : DATA;
      DATA:   if (accept && last_byte && words_left == 16'd1) state_nxt = DONE;
      DONE:   if (start) state_nxt = HDR_HI;
      default: state_nxt = HDR_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      n_hi       <= 8'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      asm_q      <= 24'd0;
      word_idx   <= 17'd0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR[ADDR_WIDTH-1:0];
      mem_wdata  <= 32'd0;
      core_rstb  <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // The address advances on the edge after each strobe, wrapping naturally.
      if (mem_we) mem_addr <= mem_addr + 1'b1;

      case (state)
        HDR_HI: if (accept) n_hi <= in_data;

        HDR_LO: if (accept) begin
          if (hdr_n != 16'd0) begin
            words_left <= hdr_n;
            byte_cnt   <= 2'd0;
            word_idx   <= 17'd0;
            mem_addr   <= BASE_ADDR[ADDR_WIDTH-1:0];
          end
          if (32'(hdr_n) > CAPACITY) err <= 1'b1;
        end

        DATA: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= {asm_q[15:0], in_data};
          if (last_byte) begin
            words_left <= words_left - 16'd1;
            word_idx   <= word_idx + 17'd1;
            // Overflow words are still consumed so the stream stays in sync.
            if (32'(word_idx) < CAPACITY) begin
              mem_we    <= 1'b1;
              mem_wdata <= {asm_q, in_data};
            end
          end
        end

        DONE: begin
          if (start) begin
            core_rstb <= 1'b0;
            err       <= 1'b0;
          end else begin
            core_rstb <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: an 8-bit-address instance and a 2-bit-address
// instance share one byte stream; writes are logged and compared to hand values.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic        in_ready, mem_we, core_rstb, busy, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic        in_ready_s, mem_we_s, core_rstb_s, busy_s, err_s;
  logic [1:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;

  prog_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rstb(rstb), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rstb(core_rstb),
    .busy(busy), .err(err)
  );

  prog_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rstb(rstb), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_s), .mem_we(mem_we_s),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .core_rstb(core_rstb_s),
    .busy(busy_s), .err(err_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t wr_q[$];
  wr_t wr_s_q[$];
  int  acc_q[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1)   wr_q.push_back('{mem_addr, mem_wdata, cyc});
    if (mem_we_s === 1'b1) wr_s_q.push_back('{{6'd0, mem_addr_s}, mem_wdata_s, cyc});
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit is_data, input int gap);
    @(negedge clk);
    check("in_ready_before_byte", in_ready, 1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (is_data) acc_q.push_back(cyc);
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    send(n[15:8], 1'b0, gap);
    send(n[7:0], 1'b0, gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send(w[31:24], 1'b1, gap);
    send(w[23:16], 1'b1, gap);
    send(w[15:8],  1'b1, gap);
    send(w[7:0],   1'b1, gap);
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_s_q.delete();
    acc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    clear_logs();
  endtask

  // Two-word load used with and without input bubbles.
  task automatic two_word_load(input int gap, input string t);
    do_reset();
    send_hdr(16'd2, gap);
    send_word(32'h2001_0010, gap);
    send_word(32'h8C0F_0100, gap);
    if (gap > 0) @(negedge clk);  // final bubble already passed the strobe edge
    else begin
      @(negedge clk);
      check({t, "_last_we"}, mem_we, 1);
      check({t, "_rstb_held"}, core_rstb, 0);
      check({t, "_busy"}, busy, 0);
      check({t, "_in_ready"}, in_ready, 0);
    end
    if (gap == 0) @(negedge clk);
    check({t, "_core_rstb"}, core_rstb, 1);
    check({t, "_we_low"}, mem_we, 0);
    check({t, "_nwrites"}, wr_q.size(), 2);
    if (wr_q.size() == 2 && acc_q.size() == 8) begin
      check({t, "_addr0"}, wr_q[0].addr, 8'd0);
      check({t, "_data0"}, wr_q[0].data, 32'h2001_0010);
      check({t, "_addr1"}, wr_q[1].addr, 8'd1);
      check({t, "_data1"}, wr_q[1].data, 32'h8C0F_0100);
      check({t, "_strobe0_cycle"}, wr_q[0].c, acc_q[3]);
      check({t, "_strobe1_cycle"}, wr_q[1].c, acc_q[7]);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_rstb", core_rstb, 0);
    check("rst_busy", busy, 1);
    check("rst_err", err, 0);

    two_word_load(0, "full_rate");
    two_word_load(1, "toggled");

    // Empty program
    do_reset();
    send_hdr(16'd0, 0);
    @(negedge clk);
    check("n0_busy", busy, 0);
    check("n0_rstb_first", core_rstb, 0);
    @(negedge clk);
    check("n0_core_rstb", core_rstb, 1);
    check("n0_err", err, 0);
    check("n0_nwrites", wr_q.size(), 0);

    // Overflow on the 4-word instance; the 256-word instance takes all five
    do_reset();
    send_hdr(16'd5, 0);
    for (int k = 1; k <= 5; k++) send_word(32'(k), 0);
    repeat (2) @(negedge clk);
    check("ovf_nwrites", wr_s_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wr_s_q.size()) begin
        check("ovf_addr", wr_s_q[k].addr, 32'(k));
        check("ovf_data", wr_s_q[k].data, 32'(k + 1));
      end
    end
    check("ovf_err", err_s, 1);
    check("ovf_core_rstb", core_rstb_s, 1);
    check("ovf_big_err", err, 0);
    check("ovf_big_nwrites", wr_q.size(), 5);
    if (wr_q.size() == 5) begin
      check("ovf_big_addr4", wr_q[4].addr, 8'd4);
      check("ovf_big_data4", wr_q[4].data, 32'd5);
    end

    // Restart from DONE clears err and re-holds the core
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_core_rstb", core_rstb_s, 0);
    check("restart_err", err_s, 0);
    check("restart_busy", busy_s, 1);
    clear_logs();
    send_hdr(16'd1, 0);
    send_word(32'h0000_000A, 0);
    repeat (2) @(negedge clk);
    check("restart_nwrites", wr_s_q.size(), 1);
    if (wr_s_q.size() == 1) begin
      check("restart_addr", wr_s_q[0].addr, 8'd0);
      check("restart_data", wr_s_q[0].data, 32'h0000_000A);
    end
    check("restart_done_rstb", core_rstb_s, 1);
    check("restart_done_err", err_s, 0);

    // Async reset mid-load
    do_reset();
    send_hdr(16'd3, 0);
    send_word(32'h1122_3344, 0);
    send(8'h55, 1'b1, 0);
    send(8'h66, 1'b1, 0);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_core_rstb", core_rstb, 0);
    check("midrst_busy", busy, 1);
    check("midrst_err", err, 0);
    @(negedge clk);
    rstb = 1'b1;
    clear_logs();
    send_hdr(16'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    repeat (2) @(negedge clk);
    check("reload_nwrites", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      check("reload_addr", wr_q[0].addr, 8'd0);
      check("reload_data", wr_q[0].data, 32'hCAFE_F00D);
    end
    check("reload_core_rstb", core_rstb, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
